// File: rtl/conv_sa_requant_if.sv
// Handshake and data bundle between the column post-processor, the requant stage and the output writer.
// Latency: none (wires only).
// Backpressure: out_vld/out_rdy toward the writer; almost_full throttles the upstream in_vld.
interface conv_sa_requant_if;
    logic               in_vld;
    logic signed [31:0] y1;
    logic signed [31:0] y2;
    logic signed [31:0] bias;
    logic signed [31:0] m1;
    logic        [5:0]  s;
    logic        [7:0]  yz;
    logic               out_vld;
    logic               out_rdy;
    logic        [15:0] out_data;
    logic               almost_full;
    logic               overflow;

    // Upstream/consumer side
    modport master (
        output in_vld, y1, y2, bias, m1, s, yz, out_rdy,
        input  out_vld, out_data, almost_full, overflow
    );

    // Requant stage side
    modport slave (
        input  in_vld, y1, y2, bias, m1, s, yz, out_rdy,
        output out_vld, out_data, almost_full, overflow
    );
endinterface

// File: rtl/conv_sa_requant.sv
// Requantizes a column pair (bias, Q1.31 scale, rounding shift, zero-point, uint8 clamp) into a byte-pair FIFO.
// Latency: 6 cycles in_vld -> out_vld with an empty FIFO; one pair per cycle throughput.
// Backpressure: out_vld/out_rdy on the output; almost_full (registered) must stop in_vld, else drops set overflow.
module conv_sa_requant #(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    conv_sa_requant_if.slave bus
);
    localparam int             AW     = $clog2(DEPTH);
    localparam int             CW     = AW + 1;
    localparam logic [CW-1:0]  FULL   = CW'(DEPTH);
    localparam logic [CW:0]    AF_LVL = (CW + 1)'(DEPTH - 1);

    // 33-bit add then clamp to the signed 32-bit range
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] y, input logic signed [31:0] b);
        logic [32:0] sum;
        sum = {y[31], y} + {b[31], b};
        if (sum[32] != sum[31]) return sum[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        return sum[31:0];
    endfunction

    function automatic logic signed [63:0] sext64(input logic signed [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Round half up toward +inf; the 64-bit rounding add is allowed to wrap
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] p, input logic [5:0] sh);
        logic [63:0] sum;
        if (sh == 6'd0) return p;
        sum = p + (64'd1 << (sh - 6'd1));
        return $signed(sum) >>> sh;
    endfunction

    // Zero-point add in 65 bits so the clamp sees the true value
    function automatic logic [7:0] clamp_u8(input logic signed [63:0] r, input logic [7:0] zp);
        logic signed [64:0] t;
        t = {r[63], r} + $signed({57'd0, zp});
        if (t[64]) return 8'd0;
        if (t > 65'sd255) return 8'd255;
        return t[7:0];
    endfunction

    logic               s1_vld_q, s2_vld_q, s3_vld_q, s4_vld_q, s5_vld_q;
    logic signed [31:0] s1_a1_q, s1_a2_q, s1_m_q;
    logic        [5:0]  s1_sh_q, s2_sh_q, s3_sh_q;
    logic        [7:0]  s1_zp_q, s2_zp_q, s3_zp_q, s4_zp_q;
    logic signed [63:0] s2_p1_q, s2_p2_q, s3_p1_q, s3_p2_q, s4_r1_q, s4_r2_q;
    logic        [7:0]  s5_q1_q, s5_q2_q;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d, remain;
    logic          out_vld_q, out_vld_d;
    logic [15:0]   out_data_q, out_data_d, wdata;
    logic          af_q, af_d, ovf_q, ovf_d;
    logic          push, drop, pop;
    logic [2:0]    inflight;
    logic [CW:0]   occ;

    // Pipeline valids; cleared immediately on reset so in-flight pairs are discarded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s3_vld_q <= 1'b0;
            s4_vld_q <= 1'b0;
            s5_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= bus.in_vld;
            s2_vld_q <= s1_vld_q;
            s3_vld_q <= s2_vld_q;
            s4_vld_q <= s3_vld_q;
            s5_vld_q <= s4_vld_q;
        end
    end

    // Datapath: bias, two-stage multiply, round/shift, zero-point/clamp; parameters ride along
    always_ff @(posedge clk) begin
        s1_a1_q <= sat_add(bus.y1, bus.bias);
        s1_a2_q <= sat_add(bus.y2, bus.bias);
        s1_m_q  <= bus.m1;
        s1_sh_q <= bus.s;
        s1_zp_q <= bus.yz;
        s2_p1_q <= sext64(s1_a1_q) * sext64(s1_m_q);
        s2_p2_q <= sext64(s1_a2_q) * sext64(s1_m_q);
        s2_sh_q <= s1_sh_q;
        s2_zp_q <= s1_zp_q;
        s3_p1_q <= s2_p1_q;
        s3_p2_q <= s2_p2_q;
        s3_sh_q <= s2_sh_q;
        s3_zp_q <= s2_zp_q;
        s4_r1_q <= round_shift(s3_p1_q, s3_sh_q);
        s4_r2_q <= round_shift(s3_p2_q, s3_sh_q);
        s4_zp_q <= s3_zp_q;
        s5_q1_q <= clamp_u8(s4_r1_q, s4_zp_q);
        s5_q2_q <= clamp_u8(s4_r2_q, s4_zp_q);
    end

    // FIFO control: full check on the pre-pop count; head register is loaded with the
    // incoming pair directly when no older entry remains, giving the 6-cycle latency
    always_comb begin
        wdata      = {s5_q2_q, s5_q1_q};
        push       = s5_vld_q && (cnt_q != FULL);
        drop       = s5_vld_q && (cnt_q == FULL);
        pop        = out_vld_q && bus.out_rdy;
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        cnt_d      = cnt_q + CW'(push) - CW'(pop);
        remain     = cnt_q - CW'(pop);
        out_vld_d  = (cnt_d != '0);
        out_data_d = out_data_q;
        if (remain == '0) begin
            if (push) out_data_d = wdata;
        end else begin
            out_data_d = mem_q[rd_ptr_d];
        end
        inflight   = {2'b0, s1_vld_q} + {2'b0, s2_vld_q} + {2'b0, s3_vld_q}
                   + {2'b0, s4_vld_q} + {2'b0, s5_vld_q};
        occ        = {1'b0, cnt_q} + {{(CW - 2){1'b0}}, inflight};
        af_d       = (occ >= AF_LVL);
        ovf_d      = ovf_q | drop;
    end

    // FIFO and output state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            af_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            af_q       <= af_d;
            ovf_q      <= ovf_d;
        end
    end

    // FIFO storage; contents are meaningless while the count says empty
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign bus.out_vld     = out_vld_q;
    assign bus.out_data    = out_data_q;
    assign bus.almost_full = af_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_conv_sa_requant.sv
module tb_conv_sa_requant;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_sa_requant_if bus();
    conv_sa_requant #(.DEPTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int y1; int y2; int bias; int m1; int s; int yz;
    } pair_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    pair_t       stim[$];
    logic [15:0] exp_q[$];
    logic [15:0] got[$];
    int          got_cyc[$];

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // Reference: plain wide-integer arithmetic following the requant rules
    function automatic logic [7:0] ref_q(int y, int bias, int m1, int s, int yz);
        longint a, p, r, t;
        a = longint'(y) + longint'(bias);
        if (a > 64'sh7FFF_FFFF) a = 64'sh7FFF_FFFF;
        if (a < -64'sh8000_0000) a = -64'sh8000_0000;
        p = a * longint'(m1);
        if (s == 0) r = p;
        else        r = (p + (longint'(1) <<< (s - 1))) >>> s;   // floor((p + 2^(s-1)) / 2^s)
        t = r + longint'(yz);
        if (t < 0)   return 8'd0;
        if (t > 255) return 8'd255;
        return t[7:0];
    endfunction

    function automatic logic [15:0] ref_pair(pair_t p);
        return {ref_q(p.y2, p.bias, p.m1, p.s, p.yz), ref_q(p.y1, p.bias, p.m1, p.s, p.yz)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(pair_t p);
        bus.in_vld = 1'b1;
        bus.y1     = p.y1;
        bus.y2     = p.y2;
        bus.bias   = p.bias;
        bus.m1     = p.m1;
        bus.s      = 6'(p.s);
        bus.yz     = 8'(p.yz);
    endtask

    task automatic idle();
        bus.in_vld = 1'b0;
    endtask

    task automatic gen_pair(output pair_t p);
        int m;
        m = $urandom;
        p.m1 = m & 32'h7FFF_FFFF;
        if ($urandom_range(1, 0) == 1) begin
            p.y1 = int'($urandom_range(4000, 0)) - 2000;
            p.y2 = int'($urandom_range(4000, 0)) - 2000;
            p.s  = int'($urandom_range(44, 28));
        end else begin
            p.y1 = $urandom;
            p.y2 = $urandom;
            p.s  = int'($urandom_range(63, 0));
        end
        p.bias = int'($urandom_range(2000, 0)) - 1000;
        p.yz   = int'($urandom_range(255, 0));
    endtask

    // Feeds pairs from stim; records model results in exp_q
    task automatic drive(input int max_items, input int max_cycles, input bit honour_af,
                         input bit gaps, output int pushed);
        pair_t p;
        pushed = 0;
        for (int c = 0; c < max_cycles && pushed < max_items; c++) begin
            if ((honour_af && bus.almost_full) || (gaps && $urandom_range(3, 0) == 0)) begin
                idle();
            end else begin
                p = stim.pop_front();
                apply(p);
                exp_q.push_back(ref_pair(p));
                pushed++;
            end
            step();
        end
        idle();
    endtask

    // Consumer: records every accepted word and the cycle it was accepted in
    task automatic collect(input int n, input int budget, input bit rnd_rdy);
        got.delete();
        got_cyc.delete();
        for (int c = 0; c < budget && got.size() < n; c++) begin
            bus.out_rdy = rnd_rdy ? 1'($urandom_range(1, 0)) : 1'b1;
            if (bus.out_vld && bus.out_rdy) begin
                got.push_back(bus.out_data);
                got_cyc.push_back(cyc);
            end
            step();
        end
        bus.out_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.out_rdy = 1'b0;
        bus.in_vld = 1'b0; bus.y1 = 0; bus.y2 = 0; bus.bias = 0; bus.m1 = 0; bus.s = 0; bus.yz = 0;
        repeat (2) step();
        tests++; if (bus.out_vld !== 1'b0) begin fails++; $display("FAIL reset_out_vld got=%b want=0", bus.out_vld); end
        tests++; if (bus.out_data !== 16'h0) begin fails++; $display("FAIL reset_out_data got=%h want=0000", bus.out_data); end
        tests++; if (bus.almost_full !== 1'b0) begin fails++; $display("FAIL reset_almost_full got=%b want=0", bus.almost_full); end
        tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got=%b want=0", bus.overflow); end
        rst = 1'b0;
        repeat (3) step();
        tests++; if (bus.out_vld !== 1'b0) begin fails++; $display("FAIL idle_out_vld got=%b want=0", bus.out_vld); end
    endtask

    task automatic test_latency();
        pair_t p;
        int n;
        p = '{100, 100, 28, 32'h4000_0000, 31, 10};
        apply(p);
        step();
        idle();
        n = 1;
        while (!bus.out_vld && n < 20) begin step(); n++; end
        tests++; if (n != 6) begin fails++; $display("FAIL latency got=%0d want=6", n); end
        tests++; if (bus.out_data !== 16'h4A4A) begin fails++; $display("FAIL latency_data got=%h want=4a4a", bus.out_data); end
        repeat (3) step();
        tests++; if (bus.out_data !== 16'h4A4A || bus.out_vld !== 1'b1) begin
            fails++; $display("FAIL hold_data got=%h/%b want=4a4a/1", bus.out_data, bus.out_vld);
        end
        bus.out_rdy = 1'b1;
        step();
        bus.out_rdy = 1'b0;
        tests++; if (bus.out_vld !== 1'b0) begin fails++; $display("FAIL pop_empties got=%b want=0", bus.out_vld); end
    endtask

    task automatic test_directed();
        logic [15:0] dexp [6];
        int pushed;
        dexp = '{16'h0C0C, 16'h837F, 16'h0005, 16'hFF00, 16'h0000, 16'h0707};
        stim.delete();
        exp_q.delete();
        stim.push_back('{3, 3, 0, 32'h4000_0000, 31, 10});
        stim.push_back('{-3, 5, 0, 32'h4000_0000, 31, 128});
        stim.push_back('{5, -7, 0, 1, 0, 0});
        stim.push_back('{-100000, 32'h7FFF_FFF0, 32'h100, 32'h4000_0000, 31, 10});
        stim.push_back('{32'h8000_0000, 32'h8000_0005, -16, 1, 0, 0});
        stim.push_back('{32'h7FFF_FFFF, 32'h8000_0001, 0, 32'h7FFF_FFFF, 63, 7});
        fork
            drive(6, 6, 1'b0, 1'b0, pushed);
            collect(6, 40, 1'b0);
        join
        tests++; if (got.size() != 6) begin fails++; $display("FAIL directed_count got=%0d want=6", got.size()); end
        for (int i = 0; i < got.size() && i < 6; i++) begin
            tests++;
            if (got[i] !== dexp[i]) begin fails++; $display("FAIL directed_%0d got=%h want=%h", i, got[i], dexp[i]); end
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        pair_t p;
        int pushed;
        stim.delete();
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin gen_pair(p); stim.push_back(p); end
        fork
            drive(16, 16, 1'b0, 1'b0, pushed);
            collect(16, 60, 1'b0);
        join
        tests++; if (got.size() != 16) begin fails++; $display("FAIL b2b_count got=%0d want=16", got.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got[i] !== exp_q[i]) begin fails++; $display("FAIL b2b_%0d got=%h want=%h", i, got[i], exp_q[i]); end
        end
        if (got.size() == 16) begin
            tests++;
            if (got_cyc[15] - got_cyc[0] != 15) begin
                fails++; $display("FAIL b2b_throughput got=%0d cycles want=15", got_cyc[15] - got_cyc[0]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        pair_t p;
        int pushed;
        stim.delete();
        exp_q.delete();
        for (int i = 0; i < 60; i++) begin gen_pair(p); stim.push_back(p); end
        fork
            drive(60, 2000, 1'b1, 1'b1, pushed);
            collect(60, 3000, 1'b1);
        join
        tests++; if (got.size() != 60) begin fails++; $display("FAIL random_count got=%0d want=60", got.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got[i] !== exp_q[i]) begin fails++; $display("FAIL random_%0d got=%h want=%h", i, got[i], exp_q[i]); end
        end
        tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL random_overflow got=%b want=0", bus.overflow); end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        pair_t p;
        int pushed;
        stim.delete();
        exp_q.delete();
        bus.out_rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin gen_pair(p); stim.push_back(p); end
        drive(20, 20, 1'b1, 1'b0, pushed);
        tests++; if (pushed != 8) begin fails++; $display("FAIL bp_accepted got=%0d want=8", pushed); end
        repeat (8) step();
        tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL bp_overflow got=%b want=0", bus.overflow); end
        tests++; if (bus.almost_full !== 1'b1) begin fails++; $display("FAIL bp_almost_full got=%b want=1", bus.almost_full); end
        tests++; if (bus.out_vld !== 1'b1 || bus.out_data !== exp_q[0]) begin
            fails++; $display("FAIL bp_head got=%h/%b want=%h/1", bus.out_data, bus.out_vld, exp_q[0]);
        end
        collect(8, 30, 1'b0);
        tests++; if (got.size() != 8) begin fails++; $display("FAIL bp_count got=%0d want=8", got.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got[i] !== exp_q[i]) begin fails++; $display("FAIL bp_%0d got=%h want=%h", i, got[i], exp_q[i]); end
        end
        if (got.size() == 8) begin
            tests++;
            if (got_cyc[7] - got_cyc[0] != 7) begin fails++; $display("FAIL bp_rate got=%0d want=7", got_cyc[7] - got_cyc[0]); end
        end
        step();
        tests++; if (bus.almost_full !== 1'b0) begin fails++; $display("FAIL bp_af_clear got=%b want=0", bus.almost_full); end
        stim.delete();
        exp_q.delete();
    endtask

    task automatic test_overflow();
        pair_t p;
        int pushed;
        stim.delete();
        exp_q.delete();
        bus.out_rdy = 1'b0;
        for (int i = 0; i < 12; i++) begin gen_pair(p); stim.push_back(p); end
        drive(12, 12, 1'b0, 1'b0, pushed);
        repeat (8) step();
        tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ovf_set got=%b want=1", bus.overflow); end
        collect(12, 30, 1'b0);
        tests++; if (got.size() != 8) begin fails++; $display("FAIL ovf_kept got=%0d want=8", got.size()); end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            tests++;
            if (got[i] !== exp_q[i]) begin fails++; $display("FAIL ovf_%0d got=%h want=%h", i, got[i], exp_q[i]); end
        end
        tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got=%b want=1", bus.overflow); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        pair_t p;
        int pushed;
        int n;
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL rst_ovf_clear got=%b want=0", bus.overflow); end
        stim.delete();
        exp_q.delete();
        bus.out_rdy = 1'b0;
        for (int i = 0; i < 7; i++) begin gen_pair(p); stim.push_back(p); end
        drive(7, 7, 1'b0, 1'b0, pushed);
        repeat (2) step();
        tests++; if (bus.out_vld !== 1'b1) begin fails++; $display("FAIL mid_pre_vld got=%b want=1", bus.out_vld); end
        #2 rst = 1'b1;
        #1;
        tests++; if (bus.out_vld !== 1'b0) begin fails++; $display("FAIL mid_async_vld got=%b want=0", bus.out_vld); end
        tests++; if (bus.almost_full !== 1'b0) begin fails++; $display("FAIL mid_async_af got=%b want=0", bus.almost_full); end
        step();
        rst = 1'b0;
        exp_q.delete();
        n = 0;
        bus.out_rdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_vld) n++;
            step();
        end
        bus.out_rdy = 1'b0;
        tests++; if (n != 0) begin fails++; $display("FAIL mid_stale got=%0d words want=0", n); end
        gen_pair(p);
        apply(p);
        step();
        idle();
        n = 1;
        while (!bus.out_vld && n < 20) begin step(); n++; end
        tests++; if (n != 6) begin fails++; $display("FAIL mid_latency got=%0d want=6", n); end
        tests++; if (bus.out_data !== ref_pair(p)) begin
            fails++; $display("FAIL mid_data got=%h want=%h", bus.out_data, ref_pair(p));
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_random();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
